// File: rtl/conv_pkg.sv
// Shared constants, state encoding and saturation helper for the convolution writer.
package conv_pkg;

  localparam int unsigned IMG_SIZE = 10;
  localparam int unsigned KER_SIZE = 3;
  localparam int unsigned OUT_SIZE = IMG_SIZE - KER_SIZE + 1;
  localparam int unsigned NWIN     = OUT_SIZE * OUT_SIZE;
  localparam int unsigned NTAP     = KER_SIZE * KER_SIZE;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned COEF_W   = 8;
  localparam int unsigned ACC_W    = 20;
  localparam int unsigned SHIFT    = 0;
  localparam int unsigned PROD_W   = PIX_W + 1 + COEF_W;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned TAP_W    = $clog2(NTAP);
  localparam int unsigned WIN_W    = $clog2(NWIN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Arithmetic shift, then clamp into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh[ACC_W-1])               return '0;
    else if (|sh[ACC_W-2:PIX_W])   return '1;
    else                           return sh[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_accum_writer_if.sv
// Tap stream in, filtered-pixel write port and status out.
interface conv_accum_writer_if;
  import conv_pkg::*;

  logic              start;
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic [COEF_W-1:0] in_coef;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [PIX_W-1:0]  out_data;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_pixel, in_coef,
    input  out_we, out_addr, out_data, busy, done
  );

  modport slave (
    input  start, in_valid, in_pixel, in_coef,
    output out_we, out_addr, out_data, busy, done
  );

endinterface

// File: rtl/conv_mac.sv
// Two-stage multiply-accumulate over one window; exposes the saturated window sum.
module conv_mac
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              tap_valid,
  input  logic              tap_first,
  input  logic              tap_last,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [COEF_W-1:0] coef,
  output logic              win_valid,
  output logic [PIX_W-1:0]  win_data_c
);

  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod;
  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [ACC_W-1:0]  acc;

  // Pixel is zero-extended so the product stays signed.
  assign prod_c = PROD_W'($signed({1'b0, pixel})) * PROD_W'($signed(coef));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else if (flush) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else begin
      p_valid <= tap_valid;
      if (tap_valid) begin
        prod    <= prod_c;
        p_first <= tap_first;
        p_last  <= tap_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      win_valid <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= p_valid & p_last;
      if (p_valid)
        acc <= p_first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

  assign win_data_c = saturate(acc);

endmodule

// File: rtl/conv_accum_writer.sv
// Frame FSM, tap/window counters and the filtered-image write port around conv_mac.
module conv_accum_writer
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  conv_accum_writer_if.slave bus
);

  state_t            state;
  state_t            next_state;
  logic [TAP_W-1:0]  tap_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic              accept_c;
  logic              tap_last_c;
  logic              win_last_c;
  logic              win_valid;
  logic [PIX_W-1:0]  win_data_c;

  // start takes priority, so a tap presented with it is dropped.
  assign accept_c   = (state == RUN) && bus.in_valid && !bus.start;
  assign tap_last_c = (tap_cnt == TAP_W'(NTAP - 1));
  assign win_last_c = (win_cnt == WIN_W'(NWIN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = RUN;
    end else begin
      case (state)
        RUN:     if (accept_c && tap_last_c && win_last_c) next_state = DRAIN;
        DRAIN:   if (bus.out_we) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt      <= '0;
      win_cnt      <= '0;
      bus.out_we   <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.busy <= (next_state == RUN) || (next_state == DRAIN);
      if (bus.start) begin
        tap_cnt      <= '0;
        win_cnt      <= '0;
        bus.out_we   <= 1'b0;
        bus.out_addr <= '0;
        bus.done     <= 1'b0;
      end else begin
        if (accept_c) begin
          tap_cnt <= tap_last_c ? '0 : tap_cnt + TAP_W'(1);
          if (tap_last_c) win_cnt <= win_cnt + WIN_W'(1);
        end
        bus.out_we <= win_valid;
        if (win_valid) bus.out_data <= win_data_c;
        if (bus.out_we) bus.out_addr <= bus.out_addr + ADDR_W'(1);
        if (state == DRAIN && bus.out_we) bus.done <= 1'b1;
      end
    end
  end

  conv_mac u_mac (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.start),
    .tap_valid  (accept_c),
    .tap_first  (tap_cnt == '0),
    .tap_last   (tap_last_c),
    .pixel      (bus.in_pixel),
    .coef       (bus.in_coef),
    .win_valid  (win_valid),
    .win_data_c (win_data_c)
  );

endmodule

// File: tb/tb_conv_accum_writer.sv
// Randomized bench for conv_accum_writer against a direct 2-D convolution model.
module tb_conv_accum_writer;
  import conv_pkg::*;

  typedef struct {
    int     addr;
    int     data;
    longint due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  int     writes = 0;
  longint last_we = -1;
  exp_t   exp_q[$];
  int     img [IMG_SIZE*IMG_SIZE];
  int     ker [NTAP];

  conv_accum_writer_if bus ();

  conv_accum_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Direct convolution of the current image/kernel at output pixel (r,c).
  function automatic int ref_pix(input int r, input int c);
    int s;
    s = 0;
    for (int kr = 0; kr < KER_SIZE; kr++)
      for (int kc = 0; kc < KER_SIZE; kc++)
        s += img[(r + kr) * IMG_SIZE + c + kc] * ker[kr * KER_SIZE + kc];
    s = s >>> SHIFT;
    if (s < 0) return 0;
    if (s > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
    return s;
  endfunction

  // Scoreboard on the write port.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_addr", longint'(bus.out_addr), e.addr);
        check("out_data", longint'(bus.out_data), e.data);
        check("we_latency", cyc, e.due);
      end
      writes++;
      if (bus.out_addr == ADDR_W'(NWIN - 1)) begin
        check("done_before_last_we", longint'(bus.done), 0);
        last_we = cyc;
      end
    end
    if (last_we >= 0 && cyc == last_we + 1) begin
      check("done_rise", longint'(bus.done), 1);
      check("busy_drop", longint'(bus.busy), 0);
    end
  end

  task automatic send_window(input int w, input int max_gap, input int ntaps);
    int r, c, gap;
    r = w / OUT_SIZE;
    c = w % OUT_SIZE;
    for (int t = 0; t < ntaps; t++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_pixel = PIX_W'($urandom);
        bus.in_coef  = COEF_W'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pixel = PIX_W'(img[(r + t / KER_SIZE) * IMG_SIZE + c + t % KER_SIZE]);
      bus.in_coef  = COEF_W'(ker[t]);
      if (t == NTAP - 1) exp_q.push_back('{addr: w, data: ref_pix(r, c), due: cyc + 3});
    end
  endtask

  task automatic drive_frame(input int max_gap);
    for (int w = 0; w < NWIN; w++) send_window(w, max_gap, NTAP);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    writes  = 0;
    last_we = -1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", longint'(bus.busy), 1);
    check("start_done", longint'(bus.done), 0);
  endtask

  task automatic end_frame(input string tag);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, longint'(bus.done), 1);
    check({tag, "_writes"}, writes, NWIN);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic fill_const(input int pix, input int coef);
    foreach (img[i]) img[i] = pix;
    foreach (ker[i]) ker[i] = coef;
  endtask

  task automatic fill_random(input int coef_lo, input int coef_hi);
    foreach (img[i]) img[i] = int'($urandom_range(255, 0));
    foreach (ker[i]) ker[i] = int'($urandom_range(coef_hi - coef_lo, 0)) + coef_lo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_coef  = '0;
    repeat (3) @(negedge clk);
    check("rst_we",   longint'(bus.out_we),   0);
    check("rst_addr", longint'(bus.out_addr), 0);
    check("rst_data", longint'(bus.out_data), 0);
    check("rst_busy", longint'(bus.busy),     0);
    check("rst_done", longint'(bus.done),     0);
    rst = 1'b0;

    // Taps offered in IDLE must be ignored.
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pixel = PIX_W'($urandom);
      bus.in_coef  = COEF_W'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_busy", longint'(bus.busy), 0);

    fill_const(10, 1);
    start_frame();
    drive_frame(0);
    end_frame("const10");

    // Taps offered in DONE must be ignored, done stays up.
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pixel = PIX_W'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("done_hold", longint'(bus.done), 1);
    check("done_ignore_writes", writes, NWIN);

    foreach (img[i]) img[i] = i;
    foreach (ker[i]) ker[i] = (i == NTAP / 2) ? 1 : 0;
    start_frame();
    drive_frame(0);
    end_frame("identity");

    fill_const(255, 127);
    start_frame();
    drive_frame(0);
    end_frame("clamp_hi");

    fill_const(255, -1);
    start_frame();
    drive_frame(0);
    end_frame("clamp_lo");

    fill_const(10, 1);
    start_frame();
    drive_frame(3);
    end_frame("const10_gaps");

    fill_random(-128, 127);
    start_frame();
    drive_frame(2);
    end_frame("random");

    // Restart mid-window; the tap presented alongside start is dropped.
    fill_random(-20, 40);
    start_frame();
    for (int w = 0; w < 20; w++) send_window(w, 0, NTAP);
    send_window(20, 0, 4);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd200;
    bus.in_coef  = 8'd50;
    check("abort_pending", exp_q.size(), 0);
    check("abort_writes", writes, 20);
    exp_q.delete();
    writes  = 0;
    last_we = -1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_done", longint'(bus.done), 0);
    check("abort_addr", longint'(bus.out_addr), 0);
    check("abort_busy", longint'(bus.busy), 1);
    drive_frame(1);
    end_frame("after_abort");

    // Asynchronous reset in the middle of a window.
    fill_random(0, 30);
    start_frame();
    for (int w = 0; w < 10; w++) send_window(w, 0, NTAP);
    send_window(10, 0, 5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_we",   longint'(bus.out_we),   0);
    check("arst_addr", longint'(bus.out_addr), 0);
    check("arst_data", longint'(bus.out_data), 0);
    check("arst_busy", longint'(bus.busy),     0);
    check("arst_done", longint'(bus.done),     0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_random(-64, 64);
    start_frame();
    drive_frame(0);
    end_frame("after_rst");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_accum_writer.md
Name: conv_accum_writer

Overview:
- Datapath/writer end of the convolution address interface.
- Consumes the stream of (image pixel, kernel coefficient) pairs that image and kernel memories return for the controller's read addresses.
- Multiplies and accumulates KER_SIZE*KER_SIZE taps per output window, scales and saturates the result, then writes one 8-bit filtered pixel per window to filtered-image memory at sequential addresses.
- Asserts done after the last window of a frame.

Parameters:
- IMG_SIZE, 10, input image side length in pixels.
- KER_SIZE, 3, kernel side length; taps per window = KER_SIZE*KER_SIZE.
- PIX_W, 8, pixel width, unsigned.
- COEF_W, 8, coefficient width, two's-complement signed.
- ACC_W, 20, accumulator width, signed; must hold KER_SIZE^2 * (2^PIX_W-1) * 2^(COEF_W-1).
- SHIFT, 0, arithmetic right shift applied to the final sum before saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a new frame.
- in_valid  in  1  in_pixel/in_coef hold one tap this cycle.
- in_pixel  in  PIX_W  unsigned image pixel.
- in_coef  in  COEF_W  signed kernel coefficient.
- out_we  out  1  write strobe to filtered-image memory, one cycle per window.
- out_addr  out  16  filtered-image write address.
- out_data  out  PIX_W  saturated filtered pixel.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  sticky frame-complete flag.

Behaviour:
- Constants: OUT_SIZE = IMG_SIZE-KER_SIZE+1; NWIN = OUT_SIZE*OUT_SIZE (64 at defaults); NTAP = KER_SIZE*KER_SIZE (9).
- Reset (asynchronous, any state):
  - state=IDLE.
  - out_we=0, out_addr=0, out_data=0, busy=0, done=0.
  - Tap counter, window counter, accumulator and pipeline valids = 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the tap completing window NWIN-1 is accepted.
  - DRAIN -> DONE when that window's out_we fires.
  - DONE holds until start, then -> RUN.
- start in any state:
  - Clears tap and window counters and out_addr, flushes the pipeline, clears done, enters RUN.
  - start wins over a simultaneous in_valid; that tap is dropped.
- Taps are accepted only in RUN with in_valid=1. in_valid in IDLE, DRAIN or DONE is ignored.
- Pipeline (2 stages):
  - Stage 1 registers the signed product of {1'b0,in_pixel} and in_coef, plus a first/last flag derived from the tap counter.
  - Stage 2: accumulator loads the product on the first tap of a window and adds it otherwise.
- Latency:
  - Tap NTAP-1 of a window accepted at edge N; out_we=1 during the cycle after edge N+2.
  - out_data and out_addr are valid in that same cycle.
- out_we is a single-cycle pulse; out_addr increments by 1 after each write and covers 0..NWIN-1 row-major.
- in_valid may drop for any number of cycles mid-window. Counters and the accumulator hold, and results are identical to a gap-free stream.
- Arithmetic:
  - The sum is ACC_W signed, arithmetic right shift by SHIFT.
  - Saturation: below 0 -> 0; above 2^PIX_W-1 -> 2^PIX_W-1; otherwise low PIX_W bits.
  - No overflow is possible at the default widths.
- Tap counter wraps NTAP-1 -> 0. The window counter stops at NWIN; extra taps cannot be accepted outside RUN.
- done rises in the cycle after the final out_we and stays high until start or rst.

Decomposition:
- Shared package conv_pkg holds:
  - IMG_SIZE, KER_SIZE, OUT_SIZE, NWIN, NTAP.
  - PIX_W, COEF_W, ACC_W.
  - State encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- One natural sub-module, conv_mac: product register, accumulator, first/last control, shift and saturation.
- The top level keeps the FSM, counters and the write port.

Test Plan:
- Constant image 10, all coefficients 1, gap-free stream of 64*9 taps -> 64 writes, addr 0..63, data 90 each; done high the cycle after addr 63.
- Identity kernel (center coefficient 1, others 0), pixel = row*10+col -> out_data at addr r*8+c equals (r+1)*10+(c+1).
- All pixels 255, all coefficients 127 -> data 255 (clamped); all coefficients -1 -> data 0 (clamped).
- Random 0-3 cycle in_valid gaps on the first scenario -> identical data/addr sequence; out_we exactly 2 edges after each window's 9th tap.
- start pulsed after 20 windows with in_valid high on the same cycle -> that tap dropped, done=0, next write at addr 0 with a correct fresh sum.
- rst asserted mid-window asynchronously -> all outputs 0 immediately; subsequent start frame produces correct values from addr 0.
